descrambler_rx_32b: RTL

Receive-side counterpart of the 10GBASE-R TX scrambler: self-synchronizing 1+x^39+x^58 descrambler on the 32-bit gearbox word stream, plus the 66b block-lock state machine. It sits between the RX gearbox (32-bit data, 2-bit sync header, even/odd word flag) and the 64b/66b decoder. It drives a bit-slip request back to the gearbox until sync headers align.

---
 rtl/pcs_pkg.sv | 28 ++
 rtl/rx_block_lock.sv | 128 ++++++++++++
 rtl/descrambler_rx_32b.sv | 92 +++++++++
 3 files changed

// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS receive definitions: sync headers, scrambler taps,
// block-lock defaults and the lock FSM state encoding.
package pcs_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int SCR_TAP_A = 38;
    localparam int SCR_TAP_B = 57;
    localparam int SCR_LEN   = 58;
    localparam int WORD_W    = 32;

    localparam int LOCK_CNT_DEF  = 64;
    localparam int ERR_LIMIT_DEF = 16;
    localparam int SLIP_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        TEST = 2'd1,
        WAIT = 2'd2
    } lock_state_t;

    // Only 01 and 10 are legal 66b sync headers.
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/rx_block_lock.sv
// 66b block-lock state machine: counts sync-header tests, declares lock,
// drops lock on too many errors and requests bit slips from the gearbox.
import pcs_pkg::*;

module rx_block_lock #(
    parameter int LOCK_CNT  = LOCK_CNT_DEF,
    parameter int ERR_LIMIT = ERR_LIMIT_DEF,
    parameter int SLIP_WAIT = SLIP_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sh_valid,
    input  logic sh_test,
    output logic block_lock,
    output logic slip
);

    localparam int SH_W  = $clog2(LOCK_CNT + 1);
    localparam int INV_W = $clog2(ERR_LIMIT + 1);

    localparam logic [SH_W-1:0]  LOCK_CNT_W  = SH_W'(LOCK_CNT);
    localparam logic [SH_W-1:0]  SLIP_WAIT_W = SH_W'(SLIP_WAIT);
    localparam logic [INV_W-1:0] ERR_LIMIT_W = INV_W'(ERR_LIMIT);

    lock_state_t      state_reg, state_next;
    logic [SH_W-1:0]  sh_cnt_reg, sh_cnt_next;
    logic [INV_W-1:0] inv_cnt_reg, inv_cnt_next;
    logic             lock_reg, lock_next;
    logic             slip_reg, slip_next;

    logic [SH_W-1:0]  sh_cnt_inc;
    logic [INV_W-1:0] inv_cnt_upd;

    assign sh_cnt_inc  = sh_cnt_reg + 1'b1;
    assign inv_cnt_upd = inv_cnt_reg + INV_W'(!sh_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= INIT;
            sh_cnt_reg  <= '0;
            inv_cnt_reg <= '0;
            lock_reg    <= 1'b0;
            slip_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sh_cnt_reg  <= sh_cnt_next;
            inv_cnt_reg <= inv_cnt_next;
            lock_reg    <= lock_next;
            slip_reg    <= slip_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sh_cnt_next  = sh_cnt_reg;
        inv_cnt_next = inv_cnt_reg;
        lock_next    = lock_reg;
        slip_next    = 1'b0;

        case (state_reg)
            INIT: begin
                sh_cnt_next  = '0;
                inv_cnt_next = '0;
                state_next   = TEST;
            end

            TEST: begin
                if (sh_test) begin
                    if (!lock_reg) begin
                        if (sh_valid) begin
                            if (sh_cnt_inc == LOCK_CNT_W) begin
                                lock_next    = 1'b1;
                                sh_cnt_next  = '0;
                                inv_cnt_next = '0;
                            end else begin
                                sh_cnt_next = sh_cnt_inc;
                            end
                        end else begin
                            slip_next    = 1'b1;
                            sh_cnt_next  = '0;
                            inv_cnt_next = '0;
                            state_next   = WAIT;
                        end
                    end else begin
                        // Error limit wins over a window ending on the same test.
                        if (inv_cnt_upd == ERR_LIMIT_W) begin
                            lock_next    = 1'b0;
                            slip_next    = 1'b1;
                            sh_cnt_next  = '0;
                            inv_cnt_next = '0;
                            state_next   = WAIT;
                        end else if (sh_cnt_inc == LOCK_CNT_W) begin
                            sh_cnt_next  = '0;
                            inv_cnt_next = '0;
                        end else begin
                            sh_cnt_next  = sh_cnt_inc;
                            inv_cnt_next = inv_cnt_upd;
                        end
                    end
                end
            end

            WAIT: begin
                // Let the gearbox settle after a slip; headers are not judged here.
                if (sh_test) begin
                    if (sh_cnt_inc == SLIP_WAIT_W) begin
                        sh_cnt_next  = '0;
                        inv_cnt_next = '0;
                        state_next   = TEST;
                    end else begin
                        sh_cnt_next = sh_cnt_inc;
                    end
                end
            end

            default: begin
                sh_cnt_next  = '0;
                inv_cnt_next = '0;
                lock_next    = 1'b0;
                state_next   = INIT;
            end
        endcase
    end

    assign block_lock = lock_reg;
    assign slip       = slip_reg;

endmodule

// File: rtl/descrambler_rx_32b.sv
// 10GBASE-R receive descrambler (1 + x^39 + x^58, self-synchronizing) on the
// 32-bit gearbox stream, with sync-header block lock and bit-slip request.
import pcs_pkg::*;

module descrambler_rx_32b #(
    parameter int LOCK_CNT  = LOCK_CNT_DEF,
    parameter int ERR_LIMIT = ERR_LIMIT_DEF,
    parameter int SLIP_WAIT = SLIP_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] din,
    input  logic [1:0]        ctrlin,
    input  logic              din_en,
    input  logic              evenin,
    output logic [WORD_W-1:0] dout,
    output logic [1:0]        ctrlout,
    output logic              dout_en,
    output logic              evenout,
    output logic              block_lock,
    output logic              slip
);

    localparam int EXT_W = SCR_LEN + WORD_W;

    logic [SCR_LEN-1:0] scr_state_reg;
    logic [SCR_LEN-1:0] scr_state_next;
    logic [WORD_W-1:0]  dout_reg;
    logic [WORD_W-1:0]  dout_next;
    logic [1:0]         ctrlout_reg;
    logic               dout_en_reg;
    logic               evenout_reg;

    // scr_ext is the received bit stream in line order: the 58 history bits
    // (oldest at index 0) followed by the 32 new bits of din.
    logic [EXT_W-1:0]   scr_ext;

    genvar gi;
    generate
        for (gi = 0; gi < SCR_LEN; gi++) begin : g_hist
            assign scr_ext[gi] = scr_state_reg[SCR_LEN-1-gi];
        end
        for (gi = 0; gi < WORD_W; gi++) begin : g_new
            assign scr_ext[SCR_LEN+gi] = din[gi];
        end
        for (gi = 0; gi < WORD_W; gi++) begin : g_out
            assign dout_next[gi] = din[gi]
                                 ^ scr_ext[gi + SCR_LEN - 1 - SCR_TAP_A]
                                 ^ scr_ext[gi + SCR_LEN - 1 - SCR_TAP_B];
        end
        for (gi = 0; gi < SCR_LEN; gi++) begin : g_state
            assign scr_state_next[gi] = scr_ext[EXT_W-1-gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            scr_state_reg <= '0;
            dout_reg      <= '0;
            ctrlout_reg   <= '0;
            dout_en_reg   <= 1'b0;
            evenout_reg   <= 1'b0;
        end else begin
            dout_en_reg <= din_en;
            evenout_reg <= evenin;
            if (din_en) begin
                dout_reg      <= dout_next;
                scr_state_reg <= scr_state_next;
                ctrlout_reg   <= ctrlin;
            end
        end
    end

    rx_block_lock #(
        .LOCK_CNT  (LOCK_CNT),
        .ERR_LIMIT (ERR_LIMIT),
        .SLIP_WAIT (SLIP_WAIT)
    ) u_block_lock (
        .clk        (clk),
        .rst        (rst),
        .sh_valid   (sh_is_valid(ctrlin)),
        .sh_test    (din_en && evenin),
        .block_lock (block_lock),
        .slip       (slip)
    );

    assign dout    = dout_reg;
    assign ctrlout = ctrlout_reg;
    assign dout_en = dout_en_reg;
    assign evenout = evenout_reg;

endmodule
